image_scan_engine: RTL and testbench

- Parametrised successor to the fixed two-row-pad sweep engine.
- Walks a 2-D image raster with its own internal x/y counters; does not depend on external near-end flags.
- Supports a runtime-configurable number of priming rows before the image and flush rows after it.
- Emits computed pixels with a valid/ready handshake towards the downstream pixel sink; sits between the frame sequencer (start/config) and the line-buffer/filter datapath.

---
 rtl/image_scan_engine_pkg.sv | 24 ++
 rtl/image_scan_engine_if.sv | 22 ++
 rtl/image_scan_engine_scan_counter.sv | 35 +++
 rtl/image_scan_engine.sv | 147 ++++++++++++++
 tb/tb_image_scan_engine.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/image_scan_engine_pkg.sv
// Shared types and helpers for the image scan engine.
// Phase encodings match the scan_state_t values.
package image_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        CALC = 2'd2,
        POST = 2'd3
    } scan_state_t;

    localparam logic [1:0] PHASE_IDLE = 2'd0;
    localparam logic [1:0] PHASE_PRE  = 2'd1;
    localparam logic [1:0] PHASE_CALC = 2'd2;
    localparam logic [1:0] PHASE_POST = 2'd3;

    function automatic logic pad_ok(
        input logic [31:0] value,
        input logic [31:0] max
    );
        return value <= max;
    endfunction

endpackage

// File: rtl/image_scan_engine_if.sv
// Pixel beat handshake between the scan engine and the pixel sink.
// The engine is master; the sink drives pixel_ready.
interface image_scan_engine_if #(
    parameter int X_W = 12,
    parameter int Y_W = 12
);
    logic           pixel_valid;
    logic           pixel_ready;
    logic [X_W-1:0] x_pos;
    logic [Y_W:0]   y_pos;
    logic           row_start;

    modport master (
        output pixel_valid, x_pos, y_pos, row_start,
        input  pixel_ready
    );

    modport slave (
        input  pixel_valid, x_pos, y_pos, row_start,
        output pixel_ready
    );
endinterface

// File: rtl/image_scan_engine_scan_counter.sv
// Column counter with wrap pulse and row-in-phase counter.
// o_last flags the wrap that closes the current phase.
module scan_counter #(
    parameter int X_W = 12,
    parameter int Y_W = 12
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_clear,
    input  logic           i_adv,
    input  logic [X_W-1:0] i_width,
    input  logic [Y_W-1:0] i_rows,
    output logic [X_W-1:0] o_x,
    output logic           o_wrap,
    output logic           o_last
);
    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_row;

    assign o_wrap = i_adv && (r_x == i_width - X_W'(1));
    assign o_last = o_wrap && (r_row == i_rows - Y_W'(1));
    assign o_x    = r_x;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_x   <= '0;
            r_row <= '0;
        end else if (i_adv) begin
            r_x <= o_wrap ? '0 : r_x + X_W'(1);
            if (o_wrap) begin
                r_row <= o_last ? '0 : r_row + Y_W'(1);
            end
        end
    end
endmodule

// File: rtl/image_scan_engine.sv
// Raster scan engine: priming rows, output rows, flush rows.
// Emits CALC-phase pixels with a valid/ready handshake.
module image_scan_engine
    import image_scan_pkg::*;
#(
    parameter int X_W     = 12,
    parameter int Y_W     = 12,
    parameter int MAX_PAD = 4,
    parameter int PAD_W   = $clog2(MAX_PAD + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [X_W-1:0]      cfg_width,
    input  logic [Y_W-1:0]      cfg_height,
    input  logic [PAD_W-1:0]    cfg_pre_rows,
    input  logic [PAD_W-1:0]    cfg_post_rows,
    image_scan_engine_if.master pix,
    output logic [1:0]          phase,
    output logic                frame_done,
    output logic                cfg_err,
    output logic                idle
);
    scan_state_t    r_state, w_next;
    logic [X_W-1:0] r_width;
    logic [Y_W-1:0] r_height;
    logic [PAD_W-1:0] r_pre, r_post;
    logic [Y_W:0]   r_y;
    logic           r_valid, r_row_start, r_done, r_err;
    logic           w_cfg_ok, w_start_ok, w_clear, w_step;
    logic           w_wrap, w_last, w_done;
    logic [X_W-1:0] w_x;
    logic [Y_W-1:0] w_rows;

    assign w_cfg_ok = (cfg_width != '0) && (cfg_height != '0)
                   && pad_ok(32'(cfg_pre_rows), 32'(MAX_PAD))
                   && pad_ok(32'(cfg_post_rows), 32'(MAX_PAD));
    assign w_start_ok = (r_state == IDLE) && start && w_cfg_ok;
    // Abort wins over any advance in the same cycle.
    assign w_clear = (r_state == IDLE) || abort;
    assign w_step  = !w_clear
                  && ((r_state != CALC) || (r_valid && pix.pixel_ready));

    always_comb begin
        w_rows = r_height;
        unique case (r_state)
            PRE:     w_rows = Y_W'(r_pre);
            POST:    w_rows = Y_W'(r_post);
            default: w_rows = r_height;
        endcase
    end

    scan_counter #(.X_W(X_W), .Y_W(Y_W)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .i_adv   (w_step),
        .i_width (r_width),
        .i_rows  (w_rows),
        .o_x     (w_x),
        .o_wrap  (w_wrap),
        .o_last  (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_start_ok)
                    w_next = (cfg_pre_rows != '0) ? PRE : CALC;
            end
            PRE: begin
                if (abort)       w_next = IDLE;
                else if (w_last) w_next = CALC;
            end
            CALC: begin
                if (abort) begin
                    w_next = IDLE;
                end else if (w_last) begin
                    if (r_post != '0) begin
                        w_next = POST;
                    end else begin
                        w_next = IDLE;
                        w_done = 1'b1;
                    end
                end
            end
            POST: begin
                if (abort) begin
                    w_next = IDLE;
                end else if (w_last) begin
                    w_next = IDLE;
                    w_done = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_row_start <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_y         <= '0;
            r_width     <= '0;
            r_height    <= '0;
            r_pre       <= '0;
            r_post      <= '0;
        end else begin
            r_done  <= w_done;
            r_err   <= (r_state == IDLE) && start && !w_cfg_ok;
            r_valid <= (w_next == CALC);
            if (w_start_ok) begin
                r_width     <= cfg_width;
                r_height    <= cfg_height;
                r_pre       <= cfg_pre_rows;
                r_post      <= cfg_post_rows;
                r_row_start <= 1'b1;
                r_y         <= '0;
            end else if (w_next == IDLE) begin
                r_row_start <= 1'b0;
                r_y         <= '0;
            end else if (w_step) begin
                r_row_start <= w_wrap;
                if (w_wrap) r_y <= r_y + (Y_W + 1)'(1);
            end
        end
    end

    assign pix.pixel_valid = r_valid;
    assign pix.x_pos       = w_x;
    assign pix.y_pos       = r_y;
    assign pix.row_start   = r_row_start;
    assign phase           = r_state;
    assign frame_done      = r_done;
    assign cfg_err         = r_err;
    assign idle            = (r_state == IDLE);
endmodule

// File: tb/tb_image_scan_engine.sv
// Bench for image_scan_engine: beat-index reference model,
// per-cycle compare, directed pins and randomized frames.
module tb_image_scan_engine;
  import image_scan_pkg::*;

  localparam int X_W = 12;
  localparam int Y_W = 12;
  localparam int MAX_PAD = 4;
  localparam int PAD_W = $clog2(MAX_PAD + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [X_W-1:0] cfg_width = '0;
  logic [Y_W-1:0] cfg_height = '0;
  logic [PAD_W-1:0] cfg_pre_rows = '0;
  logic [PAD_W-1:0] cfg_post_rows = '0;
  logic [1:0] phase;
  logic frame_done, cfg_err, idle;

  image_scan_engine_if #(.X_W(X_W), .Y_W(Y_W)) pix ();

  image_scan_engine #(
    .X_W(X_W), .Y_W(Y_W), .MAX_PAD(MAX_PAD), .PAD_W(PAD_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .cfg_width(cfg_width),
    .cfg_height(cfg_height),
    .cfg_pre_rows(cfg_pre_rows),
    .cfg_post_rows(cfg_post_rows),
    .pix(pix),
    .phase(phase),
    .frame_done(frame_done),
    .cfg_err(cfg_err),
    .idle(idle)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: a frame is a linear list of beats; index -> (x,y,phase).
  bit m_act = 1'b0;
  bit m_done = 1'b0;
  bit m_err = 1'b0;
  int m_idx = 0;
  int m_w, m_h, m_pre, m_post;

  function automatic int m_phase();
    int y;
    if (!m_act) return 0;
    y = m_idx / m_w;
    if (y < m_pre) return 1;
    if (y < m_pre + m_h) return 2;
    return 3;
  endfunction

  always @(posedge clk) begin
    m_done = 1'b0;
    m_err = 1'b0;
    if (rst) begin
      m_act = 1'b0;
      m_idx = 0;
    end else if (!m_act) begin
      if (start) begin
        if (cfg_width != 0 && cfg_height != 0 &&
            int'(cfg_pre_rows) <= MAX_PAD &&
            int'(cfg_post_rows) <= MAX_PAD) begin
          m_w = int'(cfg_width);
          m_h = int'(cfg_height);
          m_pre = int'(cfg_pre_rows);
          m_post = int'(cfg_post_rows);
          m_act = 1'b1;
          m_idx = 0;
        end else begin
          m_err = 1'b1;
        end
      end
    end else if (abort) begin
      m_act = 1'b0;
      m_idx = 0;
    end else if (m_phase() != 2 || pix.pixel_ready) begin
      m_idx++;
      if (m_idx == (m_pre + m_h + m_post) * m_w) begin
        m_act = 1'b0;
        m_done = 1'b1;
        m_idx = 0;
      end
    end
  end

  always @(negedge clk) begin
    int ph, ex, ey;
    if (chk_en) begin
      ph = m_phase();
      ex = m_act ? m_idx % m_w : 0;
      ey = m_act ? m_idx / m_w : 0;
      chk("phase", 32'(phase), ph);
      chk("pixel_valid", 32'(pix.pixel_valid), 32'(ph == 2));
      chk("x_pos", 32'(pix.x_pos), ex);
      chk("y_pos", 32'(pix.y_pos), ey);
      chk("row_start", 32'(pix.row_start), 32'(m_act && ex == 0));
      chk("frame_done", 32'(frame_done), 32'(m_done));
      chk("cfg_err", 32'(cfg_err), 32'(m_err));
      chk("idle", 32'(idle), 32'(!m_act));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int w, input int h,
                         input int pr, input int po);
    cfg_width = X_W'(w);
    cfg_height = Y_W'(h);
    cfg_pre_rows = PAD_W'(pr);
    cfg_post_rows = PAD_W'(po);
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      start = 1'b0;
      if (frame_done) seen = 1'b1;
    end
    chk(name, 32'(seen), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int beats, calc_cyc;
    bit hit;
    pix.pixel_ready = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_idle", 32'(idle), 1);
    chk("rst_valid", 32'(pix.pixel_valid), 0);
    rst = 1'b0;
    tick();

    // Frame 1: 4x3, pre 1, post 2, no backpressure.
    set_cfg(4, 3, 1, 2);
    start = 1'b1;
    for (int cyc = 1; cyc <= 25; cyc++) begin
      tick();
      start = 1'b0;
      if (cyc == 1) chk("f1_c1_phase", 32'(phase), 32'(PHASE_PRE));
      if (cyc == 4) chk("f1_c4_x", 32'(pix.x_pos), 3);
      if (cyc == 5) begin
        chk("f1_c5_valid", 32'(pix.pixel_valid), 1);
        chk("f1_c5_y", 32'(pix.y_pos), 1);
      end
      if (cyc == 16) begin
        chk("f1_c16_x", 32'(pix.x_pos), 3);
        chk("f1_c16_y", 32'(pix.y_pos), 3);
      end
      if (cyc == 17) chk("f1_c17_phase", 32'(phase), 32'(PHASE_POST));
      if (cyc == 24) chk("f1_c24_y", 32'(pix.y_pos), 5);
      if (cyc == 25) begin
        chk("f1_c25_done", 32'(frame_done), 1);
        chk("f1_c25_idle", 32'(idle), 1);
      end
    end
    tick();

    // Frame 2: same config, ready low on odd cycles.
    start = 1'b1;
    beats = 0;
    calc_cyc = 0;
    hit = 1'b0;
    for (int cyc = 1; cyc <= 45 && !hit; cyc++) begin
      tick();
      start = 1'b0;
      pix.pixel_ready = (cyc % 2 == 0);
      if (phase == PHASE_CALC) calc_cyc++;
      if (pix.pixel_valid && pix.pixel_ready) begin
        chk("f2_beat_x", 32'(pix.x_pos), beats % 4);
        chk("f2_beat_y", 32'(pix.y_pos), 1 + beats / 4);
        beats++;
      end
      if (frame_done) begin
        hit = 1'b1;
        chk("f2_done_cycle", cyc, 37);
      end
    end
    chk("f2_done_seen", 32'(hit), 1);
    chk("f2_beats", beats, 12);
    chk("f2_calc_cycles", calc_cyc, 24);
    pix.pixel_ready = 1'b1;
    tick();

    // Frame 3: width 1, two output rows, no pads.
    set_cfg(1, 2, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("f3_c1_phase", 32'(phase), 32'(PHASE_CALC));
    chk("f3_c1_rs", 32'(pix.row_start), 1);
    tick();
    chk("f3_c2_y", 32'(pix.y_pos), 1);
    chk("f3_c2_rs", 32'(pix.row_start), 1);
    tick();
    chk("f3_c3_done", 32'(frame_done), 1);
    tick();

    // Rejected starts.
    set_cfg(4, 0, 1, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rej_h0_err", 32'(cfg_err), 1);
    chk("rej_h0_idle", 32'(idle), 1);
    tick();
    chk("rej_h0_err_pulse", 32'(cfg_err), 0);
    set_cfg(4, 3, MAX_PAD + 1, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rej_pad_err", 32'(cfg_err), 1);
    tick();

    // Abort at (2,2) in CALC, then a full frame.
    set_cfg(4, 3, 0, 1);
    start = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      tick();
      start = 1'b0;
      if (phase == PHASE_CALC && pix.x_pos == 2 && pix.y_pos == 2) begin
        hit = 1'b1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle", 32'(idle), 1);
        chk("abort_valid", 32'(pix.pixel_valid), 0);
        chk("abort_done", 32'(frame_done), 0);
      end
    end
    chk("abort_reached", 32'(hit), 1);
    tick();
    start = 1'b1;
    wait_done("post_abort_frame", 40);
    tick();

    // Busy starts ignored, then reset mid-POST.
    set_cfg(3, 2, 1, 3);
    start = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      tick();
      start = (i % 3 == 0);
      if (phase == PHASE_POST && pix.x_pos == 1) hit = 1'b1;
    end
    chk("post_reached", 32'(hit), 1);
    start = 1'b0;
    rst = 1'b1;
    tick();
    chk("rst_mid_idle", 32'(idle), 1);
    chk("rst_mid_y", 32'(pix.y_pos), 0);
    chk("rst_mid_rs", 32'(pix.row_start), 0);
    rst = 1'b0;
    tick();

    // Randomized frames with backpressure, busy starts and aborts.
    for (int f = 0; f < 40; f++) begin
      set_cfg(($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 6),
              ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 4),
              $urandom_range(0, 5), $urandom_range(0, 4));
      start = 1'b1;
      tick();
      hit = 1'b0;
      for (int i = 0; i < 400 && m_act; i++) begin
        pix.pixel_ready = ($urandom_range(0, 3) != 0);
        start = ($urandom_range(0, 7) == 0);
        abort = ($urandom_range(0, 59) == 0);
        set_cfg($urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 7), $urandom_range(0, 7));
        tick();
      end
      chk("rand_frame_bound", 32'(m_act), 0);
      start = 1'b0;
      abort = 1'b0;
      pix.pixel_ready = 1'b1;
      tick();
    end

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
